// File: rtl/bus_xfer_sequencer.sv
//==============================================================================
// Module : bus_xfer_sequencer
// Brief  : Queues register-transfer commands and sequences each one onto the
//          single bus as a one-hot source out-enable plus a destination load.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bus_xfer_sequencer #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 24,
    parameter int NDST  = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [4:0]      cmd_src,
    input  logic [4:0]      cmd_dst,
    input  logic            hold,
    input  logic            err_clr,
    output logic [NSRC-1:0] src_oe,
    output logic [NDST-1:0] dst_in,
    output logic            busy,
    output logic            err_illegal,
    output logic [2:0]      fifo_count
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam int              c_cw      = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
    localparam logic [5:0]      c_nsrc    = 6'(NSRC);
    localparam logic [5:0]      c_ndst    = 6'(NDST);
    localparam logic [NSRC-1:0] c_src_one = NSRC'(1);
    localparam logic [NDST-1:0] c_dst_one = NDST'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    logic [9:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] r_old;
    logic            r_init;
    state_t          r_state;
    logic [4:0]      r_src;
    logic [4:0]      r_dst;

    state_t          w_state_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;
    logic            w_can_pop;
    logic            w_legal;
    logic [4:0]      w_head_src;
    logic [4:0]      w_head_dst;
    logic [4:0]      w_src_nxt;
    logic [4:0]      w_dst_nxt;
    logic [NSRC-1:0] w_src_oe_nxt;
    logic [NDST-1:0] w_dst_in_nxt;

    assign cmd_ready  = r_init && (r_count < c_depth);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_head_src = r_mem[r_rptr][9:5];
    assign w_head_dst = r_mem[r_rptr][4:0];
    assign w_legal    = ({1'b0, w_head_src} < c_nsrc) && ({1'b0, w_head_dst} < c_ndst);
    // r_old counts entries written at least one edge ago; only those may issue.
    assign w_can_pop  = (r_old != '0) && !hold;
    assign busy       = (r_count != '0) || (r_state != IDLE);
    assign fifo_count = 3'(r_count);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_src, cmd_dst};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        case (r_state)
            IDLE, LATCH: begin
                w_state_nxt = IDLE;
                if (w_can_pop) begin
                    w_pop = 1'b1;
                    if (w_legal) begin
                        w_state_nxt = DRIVE;
                        w_src_nxt   = w_head_src;
                        w_dst_nxt   = w_head_dst;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            DRIVE:   w_state_nxt = LATCH;
            default: w_state_nxt = IDLE;
        endcase

        w_src_oe_nxt = '0;
        w_dst_in_nxt = '0;
        if (w_state_nxt != IDLE) begin
            w_src_oe_nxt = c_src_one << w_src_nxt;
        end
        if (w_state_nxt == LATCH) begin
            w_dst_in_nxt = c_dst_one << w_dst_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_old       <= '0;
            r_init      <= 1'b0;
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            src_oe      <= '0;
            dst_in      <= '0;
            err_illegal <= 1'b0;
        end else begin
            r_init  <= 1'b1;
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            src_oe  <= w_src_oe_nxt;
            dst_in  <= w_dst_in_nxt;
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            r_old   <= r_count - c_cw'(w_pop);
            if (w_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            if (w_err_set) begin
                err_illegal <= 1'b1;
            end else if (err_clr) begin
                err_illegal <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_sequencer.sv
//==============================================================================
// Module : tb_bus_xfer_sequencer
// Brief  : Directed scenarios plus randomized traffic against a timing model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_bus_xfer_sequencer;

    localparam int DEPTH = 4;
    localparam int NSRC  = 24;
    localparam int NDST  = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [4:0]      cmd_src = '0;
    logic [4:0]      cmd_dst = '0;
    logic            hold = 1'b0;
    logic            err_clr = 1'b0;
    logic [NSRC-1:0] src_oe;
    logic [NDST-1:0] dst_in;
    logic            busy;
    logic            err_illegal;
    logic [2:0]      fifo_count;

    bus_xfer_sequencer #(.DEPTH(DEPTH), .NSRC(NSRC), .NDST(NDST)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .hold(hold), .err_clr(err_clr),
        .src_oe(src_oe), .dst_in(dst_in), .busy(busy), .err_illegal(err_illegal),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of commands stamped with their push edge.
    // A command may issue two edges after it was pushed; a legal issue blocks
    // the next issue for two edges, an illegal drop for one.
    typedef struct {
        logic [4:0] src;
        logic [4:0] dst;
        int         t;
    } cmd_t;

    cmd_t            q[$];
    int              t_now = 0;
    int              next_pop = 0;
    int              last_start = -100;
    logic [4:0]      cur_src = '0;
    logic [4:0]      cur_dst = '0;
    bit              m_err = 0;
    bit              m_init = 0;
    logic [NSRC-1:0] e_src;
    logic [NDST-1:0] e_dst;
    bit              e_busy;
    bit              e_ready;

    task automatic model_eval();
        logic [NSRC-1:0] one_s;
        logic [NDST-1:0] one_d;
        one_s  = 1;
        one_d  = 1;
        e_src  = (t_now == last_start || t_now == last_start + 1) ? (one_s << cur_src) : '0;
        e_dst  = (t_now == last_start + 1) ? (one_d << cur_dst) : '0;
        e_busy = (q.size() != 0) || (t_now <= last_start + 1);
        e_ready = m_init && (q.size() < DEPTH);
    endtask

    task automatic model_reset();
        q.delete();
        last_start = -100;
        next_pop   = 0;
        m_err      = 0;
        m_init     = 0;
        model_eval();
    endtask

    task automatic tick();
        bit   ready_pre;
        bit   set_err;
        cmd_t c;
        @(posedge clk);
        t_now++;
        ready_pre = m_init && (q.size() < DEPTH);
        set_err   = 0;
        if (rst_n) begin
            if (!hold && q.size() > 0 && q[0].t <= t_now - 2 && t_now >= next_pop) begin
                c = q.pop_front();
                if (c.src < NSRC && c.dst < NDST) begin
                    last_start = t_now;
                    cur_src    = c.src;
                    cur_dst    = c.dst;
                    next_pop   = t_now + 2;
                end else begin
                    set_err  = 1;
                    m_err    = 1;
                    next_pop = t_now + 1;
                end
            end
            if (err_clr && !set_err) m_err = 0;
            if (cmd_valid && ready_pre) begin
                c.src = cmd_src;
                c.dst = cmd_dst;
                c.t   = t_now;
                q.push_back(c);
            end
            m_init = 1;
        end
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        checks++;
        if (src_oe !== '0 || dst_in !== '0 || busy !== 1'b0 || fifo_count !== 3'd0 ||
            err_illegal !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: src_oe=%h dst_in=%h busy=%b cnt=%0d err=%b rdy=%b, want all 0",
                     src_oe, dst_in, busy, fifo_count, err_illegal, cmd_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_edge: rdy=%b cnt=%0d busy=%b want 1/0/0", cmd_ready, fifo_count, busy);
        end
    endtask

    task automatic test_single();
        cmd_valid = 1'b1; cmd_src = 5'd3; cmd_dst = 5'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (src_oe !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_e1: src_oe=%h rdy=%b want 0/1", src_oe, cmd_ready);
        end
        tick();
        checks++;
        if (src_oe !== 24'h000008 || dst_in !== 24'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_drive: src_oe=%h dst_in=%h want 000008/000000", src_oe, dst_in);
        end
        tick();
        checks++;
        if (src_oe !== 24'h000008 || dst_in !== 24'h000004 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_latch: src_oe=%h dst_in=%h want 000008/000004", src_oe, dst_in);
        end
        tick();
        checks++;
        if (src_oe !== '0 || dst_in !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: src_oe=%h dst_in=%h busy=%b want 0/0/0", src_oe, dst_in, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]      srcs[4];
        logic [4:0]      dsts[4];
        logic [NSRC-1:0] one_s;
        logic [NDST-1:0] one_d;
        int pulses = 0, maxc = 0, multi = 0, order_bad = 0;
        srcs = '{5'd1, 5'd5, 5'd5, 5'd9};
        dsts = '{5'd4, 5'd6, 5'd7, 5'd8};
        one_s = 1;
        one_d = 1;
        for (int c = 0; c < 16; c++) begin
            if (c < 4) begin
                cmd_valid = 1'b1; cmd_src = srcs[c]; cmd_dst = dsts[c];
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            if ($countones(src_oe) > 1 || $countones(dst_in) > 1) multi++;
            if (dst_in != '0) begin
                if (pulses >= 4 || c != 3 + 2 * pulses ||
                    dst_in !== (one_d << dsts[pulses]) || src_oe !== (one_s << srcs[pulses]))
                    order_bad++;
                pulses++;
            end
        end
        checks++;
        if (maxc != 3) begin
            errors++;
            $display("FAIL b2b_max_count: got %0d want 3", maxc);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL b2b_onehot: multi-hot cycles %0d want 0", multi);
        end
        checks++;
        if (pulses != 4 || order_bad != 0) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses, %0d out of order/spacing, want 4/0", pulses, order_bad);
        end
    endtask

    task automatic test_hold_full();
        int pulses = 0;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_src = 5'(8 + i); cmd_dst = 5'(i);
            tick();
        end
        cmd_src = 5'd12; cmd_dst = 5'd4;
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || fifo_count !== 3'd4 || src_oe !== '0) begin
            errors++;
            $display("FAIL hold_full: rdy=%b cnt=%0d src_oe=%h want 0/4/0", cmd_ready, fifo_count, src_oe);
        end
        hold = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (src_oe !== 24'h000100 || fifo_count !== 3'd3 || cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_release: src_oe=%h cnt=%0d rdy=%b want 000100/3/1",
                             src_oe, fifo_count, cmd_ready);
                end
            end
            if (c == 1) begin
                checks++;
                if (fifo_count !== 3'd4) begin
                    errors++;
                    $display("FAIL hold_fifth_push: cnt=%0d want 4", fifo_count);
                end
                cmd_valid = 1'b0;
            end
            if (dst_in != '0) pulses++;
        end
        checks++;
        if (pulses != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_drain: pulses=%0d busy=%b want 5/0", pulses, busy);
        end
    endtask

    task automatic test_illegal();
        cmd_valid = 1'b1; cmd_src = 5'd25; cmd_dst = 5'd1;
        tick();
        cmd_src = 5'd23; cmd_dst = 5'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (err_illegal !== 1'b1 || src_oe !== '0 || dst_in !== '0) begin
            errors++;
            $display("FAIL illegal_drop: err=%b src_oe=%h dst_in=%h want 1/0/0", err_illegal, src_oe, dst_in);
        end
        tick();
        checks++;
        if (src_oe !== 24'h800000 || dst_in !== '0) begin
            errors++;
            $display("FAIL illegal_next: src_oe=%h dst_in=%h want 800000/000000", src_oe, dst_in);
        end
        tick();
        checks++;
        if (dst_in !== 24'h000001 || err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_latch: dst_in=%h err=%b want 000001/1", dst_in, err_illegal);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got %b want 0", err_illegal);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_src = 5'(2 + i); cmd_dst = 5'(3 + i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (dst_in !== 24'h000008 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL mid_latch_setup: dst_in=%h cnt=%0d want 000008/2", dst_in, fifo_count);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (src_oe !== '0 || dst_in !== '0) begin
            errors++;
            $display("FAIL async_reset: src_oe=%h dst_in=%h want 0/0", src_oe, dst_in);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: cnt=%0d busy=%b want 0/0", fifo_count, busy);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (src_oe != '0 || dst_in != '0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL post_reset_strobes: %0d strobe cycles want 0", stray);
        end
    endtask

    task automatic test_hold_in_drive();
        cmd_valid = 1'b1; cmd_src = 5'd0; cmd_dst = 5'd7;
        tick();
        cmd_src = 5'd1; cmd_dst = 5'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        hold = 1'b1;
        checks++;
        if (src_oe !== 24'h000001 || dst_in !== '0) begin
            errors++;
            $display("FAIL hdrive_drive: src_oe=%h dst_in=%h want 000001/0", src_oe, dst_in);
        end
        tick();
        checks++;
        if (src_oe !== 24'h000001 || dst_in !== 24'h000080) begin
            errors++;
            $display("FAIL hdrive_latch: src_oe=%h dst_in=%h want 000001/000080", src_oe, dst_in);
        end
        tick();
        tick();
        checks++;
        if (src_oe !== '0 || dst_in !== '0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL hdrive_wait: src_oe=%h dst_in=%h cnt=%0d want 0/0/1", src_oe, dst_in, fifo_count);
        end
        hold = 1'b0;
        tick();
        checks++;
        if (src_oe !== 24'h000002) begin
            errors++;
            $display("FAIL hdrive_resume: src_oe=%h want 000002", src_oe);
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_src   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            cmd_dst   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            hold      = ($urandom_range(0, 3) == 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            if (c >= 380) begin
                cmd_valid = 1'b0;
                hold      = 1'b0;
            end
            tick();
            checks++;
            if (src_oe !== e_src || dst_in !== e_dst || busy !== e_busy || cmd_ready !== e_ready ||
                err_illegal !== m_err || fifo_count !== 3'(q.size())) begin
                errors++;
                $display("FAIL random_cycle%0d: src_oe=%h/%h dst_in=%h/%h busy=%b/%b rdy=%b/%b err=%b/%b cnt=%0d/%0d (got/want)",
                         c, src_oe, e_src, dst_in, e_dst, busy, e_busy, cmd_ready, e_ready,
                         err_illegal, m_err, fifo_count, q.size());
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_illegal();
        test_reset_mid();
        test_hold_in_drive();
        test_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
- Control-side stage directly upstream of the 32:5 bus source encoder in the single-bus datapath.
- Accepts queued register-transfer commands (source code, destination code) and sequences each one onto the bus.
- Per transfer: drives exactly one source out-enable strobe, which the encoder turns into the bus mux select, then pulses the matching destination load strobe.
- Guarantees at most one source drives the bus at any time and flags illegal codes.

Parameters:
- DEPTH, 4: command FIFO entries (power of 2, ≥2).
- NSRC, 24: number of bus sources; legal src codes 0..NSRC-1.
- NDST, 24: number of bus destinations; legal dst codes 0..NDST-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (count < DEPTH).
- cmd_src  in  5  source code; bit mapping matches the encoder (0=Cout, 1=inPort, 2=MDR, 3=PC, 4=ZLO, 5=ZHI, 6=LO, 7=HI, 8=r15 … 23=r0).
- cmd_dst  in  5  destination code, same numbering.
- hold  in  1  stall: blocks starting a new transfer.
- err_clr  in  1  clears err_illegal.
- src_oe  out  NSRC  one-hot source out-enables (feeds r0out..Cout).
- dst_in  out  NDST  one-hot destination load strobes.
- busy  out  1  FIFO non-empty or state ≠ IDLE.
- err_illegal  out  1  sticky illegal-code flag.
- fifo_count  out  3  current FIFO occupancy (0..DEPTH).

Behaviour:
- Reset is asynchronous. On reset: state=IDLE, FIFO empty, src_oe=0, dst_in=0, err_illegal=0, fifo_count=0, busy=0. cmd_ready rises on the first edge after release.
- Push: occurs when cmd_valid && cmd_ready at a rising edge. cmd_ready is registered-free (= fifo_count < DEPTH). The FIFO wraps its read/write pointers modulo DEPTH.
- Pop: a command is popped when its head is consumed (see FSM). Push and pop in the same cycle leave the count unchanged. When full, no push is possible in that cycle.
- FSM states: IDLE, DRIVE, LATCH. All outputs are registered.
  - IDLE: if FIFO non-empty && !hold, pop the head.
    - Legal src and dst → DRIVE.
    - src ≥ NSRC or dst ≥ NDST → drop the command, set err_illegal, stay IDLE (one cycle consumed, no strobes).
  - DRIVE: src_oe[src]=1, dst_in=0. Next state is LATCH unconditionally.
  - LATCH: src_oe[src] stays 1 and dst_in[dst]=1 for exactly one cycle.
    - If FIFO non-empty && !hold, pop the next head and go directly to DRIVE (or to IDLE with error if that head is illegal).
    - Otherwise → IDLE.
- Outputs in IDLE: src_oe=0, dst_in=0.
- Latency: command accepted at edge N into an empty FIFO while IDLE.
  - src_oe visible after edge N+2 (FIFO write N, pop N+1).
  - dst_in visible after edge N+3.
- Throughput: one transfer per 2 cycles back-to-back. src_oe stays asserted continuously across back-to-back transfers only if it is the same source; otherwise it switches one-hot with no overlap cycle.
- hold only gates starting a transfer. A transfer already in DRIVE always completes LATCH.
- src == dst is legal (self-load).
- err_illegal: set has priority over err_clr when both occur in the same cycle; otherwise err_clr clears it.
- Invariants: popcount(src_oe) ≤ 1, popcount(dst_in) ≤ 1, and dst_in non-zero implies src_oe non-zero.
- Reset mid-transfer: all strobes are forced to 0 immediately (asynchronous) and the FIFO contents are discarded.

Test Plan:
- Reset, then push src=3 (PC), dst=2 (MDR) at edge 0.
  - Edges 1–3: cmd_ready=1.
  - src_oe=24'h000008 for 2 cycles.
  - dst_in=24'h000004 in the 2nd cycle only.
  - Then both outputs 0 and busy=0.
- Push 4 commands back-to-back with no hold.
  - fifo_count reaches 3 (not 4), since draining starts immediately.
  - Transfers are issued in order at 2-cycle spacing.
  - src_oe is never multi-hot.
  - 4 dst_in pulses total.
- Assert hold, push 5 commands.
  - 4 are accepted and the 5th stalls with cmd_ready=0, fifo_count=4.
  - Deassert hold: draining starts on the next edge and the 5th command is accepted after the first pop.
- Push src=25, dst=1.
  - err_illegal=1 with no strobes.
  - A following legal command (src=23, dst=0) executes with src_oe bit 23 set.
  - Pulse err_clr → err_illegal=0.
- Assert rst_n=0 while in LATCH with 2 queued commands.
  - src_oe and dst_in go to 0 without waiting for a clock edge.
  - After release: fifo_count=0, busy=0, no further strobes.
- Assert hold during DRIVE of src=0, dst=7.
  - The LATCH cycle still occurs (dst_in=24'h000080).
  - The next queued command waits until hold is deasserted.
